gcbp_bram_read_sequencer: RTL and testbench

- Read-side counterpart of the GCBP sub-image write-enable decoder.
- After one frame's bit-plane data has been written into the 4x4 array of sub-image BRAMs, this block walks all 16 BRAMs in sub-image order through their B ports. Within each BRAM it walks every word.
- It muxes the selected BRAM output and streams it downstream with a valid/ready handshake, tagged with the sub-image coordinates and word address.

---
 rtl/gcbp_bram_read_sequencer.sv | 153 +++++++++++++++
 tb/tb_gcbp_bram_read_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gcbp_bram_read_sequencer.sv
// gcbp_bram_read_sequencer
// Walks the 4x4 array of GCBP sub-image BRAMs through their B ports, BRAM 0..15 in
// sub-image order (n = 4*vert + hori) and word 0..WORDS_PER_BRAM-1 within each, and
// streams the words out on a valid/ready interface tagged with their coordinates.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              pulse that begins a pass (ignored unless idle)
//   busy, done         pass in progress / one-cycle completion pulse
//   bram_array_enb     one-hot port-B enable, bit n selects BRAM n
//   bram_array_addrb   shared port-B address
//   bram_array_doutb   concatenated port-B outputs, BRAM n at [n*DATA_WIDTH +: DATA_WIDTH]
//   out_*              output stream: data, vert/hori tags, word address, valid, ready
module gcbp_bram_read_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned WORDS_PER_BRAM = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              bram_array_enb,
  output logic [ADDR_WIDTH-1:0]    bram_array_addrb,
  input  logic [16*DATA_WIDTH-1:0] bram_array_doutb,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [1:0]               out_vert_subimage,
  output logic [1:0]               out_hori_subimage,
  output logic [ADDR_WIDTH-1:0]    out_word_addr,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastWord = ADDR_WIDTH'(WORDS_PER_BRAM - 1);

  state_e                 state_q, state_d;
  logic [3:0]             bram_cnt_q, bram_cnt_d;
  logic [ADDR_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0]  addrb_q, addrb_d;
  logic                   inflight_q, inflight_d;
  logic [3:0]             tag_bram_q, tag_bram_d;
  logic [ADDR_WIDTH-1:0]  tag_word_q, tag_word_d;

  logic [DATA_WIDTH-1:0]  fifo_data_q [2];
  logic [3:0]             fifo_bram_q [2];
  logic [ADDR_WIDTH-1:0]  fifo_word_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;

  logic                   issue, push, pop;
  logic [2:0]             occupancy;
  logic [DATA_WIDTH-1:0]  push_data;

  assign push      = inflight_q;
  assign pop       = (fifo_cnt_q != 2'd0) && out_ready;
  assign push_data = bram_array_doutb[32'(tag_bram_q) * DATA_WIDTH +: DATA_WIDTH];
  assign fifo_cnt_d = 2'(fifo_cnt_q + {1'b0, push} - {1'b0, pop});

  // A word leaving the FIFO this cycle frees its slot for the read issued now, which keeps
  // the stream at one word per cycle while guaranteeing FIFO + inflight never exceeds 2.
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    state_d    = state_q;
    bram_cnt_d = bram_cnt_q;
    word_cnt_d = word_cnt_q;
    issue      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRead;
          bram_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
      StRead: begin
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (word_cnt_q == LastWord) begin
            word_cnt_d = '0;
            bram_cnt_d = bram_cnt_q + 4'd1;
            if (bram_cnt_q == 4'd15) state_d = StDrain;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // Looking at the next FIFO count lets done follow the final pop by one cycle.
        if (!inflight_q && fifo_cnt_d == 2'd0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inflight_d = issue;
    tag_bram_d = issue ? bram_cnt_q : tag_bram_q;
    tag_word_d = issue ? word_cnt_q : tag_word_q;
    addrb_d    = issue ? word_cnt_q : addrb_q;
  end

  assign bram_array_enb   = issue ? (16'd1 << bram_cnt_q) : 16'd0;
  assign bram_array_addrb = addrb_d;
  assign busy             = (state_q == StRead) || (state_q == StDrain);
  assign done             = (state_q == StDone);

  assign out_valid         = (fifo_cnt_q != 2'd0);
  assign out_data          = fifo_data_q[rd_ptr_q];
  assign out_vert_subimage = fifo_bram_q[rd_ptr_q][3:2];
  assign out_hori_subimage = fifo_bram_q[rd_ptr_q][1:0];
  assign out_word_addr     = fifo_word_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bram_cnt_q <= '0;
      word_cnt_q <= '0;
      addrb_q    <= '0;
      inflight_q <= 1'b0;
      tag_bram_q <= '0;
      tag_word_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_bram_q[i] <= '0;
        fifo_word_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      bram_cnt_q <= bram_cnt_d;
      word_cnt_q <= word_cnt_d;
      addrb_q    <= addrb_d;
      inflight_q <= inflight_d;
      tag_bram_q <= tag_bram_d;
      tag_word_q <= tag_word_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_bram_q[wr_ptr_q] <= tag_bram_q;
        fifo_word_q[wr_ptr_q] <= tag_word_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_gcbp_bram_read_sequencer.sv
// Directed bench for gcbp_bram_read_sequencer with WORDS_PER_BRAM=4 (64 words per pass).
// BRAM n holds word {16'(n), 16'(addr)}; a behavioural 1-cycle-latency BRAM model
// drives bram_array_doutb.
module tb_gcbp_bram_read_sequencer;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [15:0] bram_array_enb;
  logic [9:0]  bram_array_addrb;
  logic [511:0] bram_array_doutb = '0;
  logic [31:0] out_data;
  logic [1:0]  out_vert_subimage, out_hori_subimage;
  logic [9:0]  out_word_addr;
  logic        out_valid;
  logic        out_ready = 1'b1;

  gcbp_bram_read_sequencer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .WORDS_PER_BRAM(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .bram_array_enb(bram_array_enb),
    .bram_array_addrb(bram_array_addrb),
    .bram_array_doutb(bram_array_doutb),
    .out_data(out_data),
    .out_vert_subimage(out_vert_subimage),
    .out_hori_subimage(out_hori_subimage),
    .out_word_addr(out_word_addr),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int n = 0; n < 16; n++) begin
      if (bram_array_enb[n]) bram_array_doutb[n*32 +: 32] <= {16'(n), 6'd0, bram_array_addrb};
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int issued, popped, rel, first_valid, done_cyc, busy_cnt, done_cnt, last_pop_rel;
  logic        hold = 1'b0;
  logic [45:0] held_fields;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle observation, sampled on the falling edge.
  task automatic monitor();
    logic        pop;
    logic [15:0] e_enb;
    logic [45:0] fields, e_word;
    int          k;
    if (!rst_n) begin
      hold = 1'b0;
      return;
    end
    fields = {out_vert_subimage, out_hori_subimage, out_word_addr, out_data};
    pop    = out_valid && out_ready;
    if (hold) check("hold_stable", {17'd0, out_valid, fields}, {17'd0, 1'b1, held_fields});
    if (bram_array_enb != 16'd0) begin
      e_enb = 16'(1 << (issued / W));
      check("enb_onehot", 64'($onehot(bram_array_enb)), 64'd1);
      check("issue_enb_addr", {38'd0, bram_array_enb, bram_array_addrb},
            {38'd0, e_enb, 10'(issued % W)});
      check("issue_room", 64'((issued - popped - int'(pop)) < 2), 64'd1);
      issued++;
    end
    if (pop) begin
      k = popped;
      e_word = {2'((k / W) >> 2), 2'((k / W) & 3), 10'(k % W), 16'(k / W), 16'(k % W)};
      check("out_word", {18'd0, fields}, {18'd0, e_word});
      popped++;
      last_pop_rel = rel;
    end
    check("no_overflow", 64'((issued - popped) <= 2), 64'd1);
    if (out_valid && first_valid < 0) first_valid = rel;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = rel;
    end
    hold        = out_valid && !out_ready;
    held_fields = fields;
  endtask

  task automatic tick(input logic rdy, input logic st);
    @(posedge clk);
    #1;
    out_ready = rdy;
    start     = st;
    @(negedge clk);
    monitor();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {3'd0, busy, done, bram_array_enb, bram_array_addrb, out_valid, out_data,
                out_vert_subimage, out_hori_subimage, out_word_addr}, 64'd0);
  endtask

  // mode 0: ready=1; 1: ready=1 plus a start at word 30; 2: random ready;
  // 3: ready dropped for 20 cycles once word 60 is at the head.
  task automatic run_pass(input int mode);
    int   stall;
    logic r, s;
    issued = 0; popped = 0; first_valid = -1; done_cyc = -1;
    busy_cnt = 0; done_cnt = 0; last_pop_rel = -1; stall = 0;
    rel = 0;
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 400 && done_cyc < 0; i++) begin
      r = 1'b1;
      s = 1'b0;
      if (mode == 1) s = (popped == 30);
      if (mode == 2) r = 1'($urandom_range(0, 1));
      if (mode == 3 && popped >= 60 && stall < 20) begin
        r = 1'b0;
        stall++;
      end
      rel = i;
      tick(r, s);
      if (mode == 3 && !r) begin
        check("stall_head", {17'd0, out_valid, done, out_vert_subimage, out_hori_subimage,
                             out_word_addr, out_data},
              {17'd0, 1'b1, 1'b0, 2'd3, 2'd3, 10'd0, 32'h000f_0000});
      end
    end
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("words_popped", 64'(popped), 64'(16 * W));
    check("words_issued", 64'(issued), 64'(16 * W));
    check("done_count", 64'(done_cnt), 64'd1);
    check("done_after_last_pop", 64'(done_cyc), 64'(last_pop_rel + 1));
    check("first_valid_cycle", 64'(first_valid), 64'd3);
    if (mode <= 1) begin
      check("done_cycle", 64'(done_cyc), 64'(16 * W + 3));
      check("busy_cycles", 64'(busy_cnt), 64'(16 * W + 2));
    end else begin
      check("busy_cycles", 64'(busy_cnt), 64'(done_cyc - 1));
    end
  endtask

  initial begin
    int aborted_done;
    #2;
    check_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    run_pass(0);
    run_pass(1);
    run_pass(2);
    run_pass(3);

    // Abandon a pass with an asynchronous reset mid-cycle.
    issued = 0; popped = 0; first_valid = -1; done_cyc = -1;
    busy_cnt = 0; done_cnt = 0; rel = 0; aborted_done = 0;
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 200 && popped < 20; i++) begin
      rel = i;
      tick(1'b1, 1'b0);
      if (done) aborted_done++;
    end
    check("mid_pass_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) begin
      tick(1'b1, 1'b0);
      check_all_zero("reset_held");
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(1'b1, 1'b0);
    if (done) aborted_done++;
    check("aborted_no_done", 64'(aborted_done), 64'd0);
    check_all_zero("idle_after_abort");

    run_pass(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
